seg_code_checker: RTL and testbench

Sequential keypad-side checker for the security system: accepts a stream of active-low 7-segment patterns (one digit per strobe), decodes each back to a BCD digit, and compares the two-digit entry against a stored code. It unlocks on a match, counts failed attempts, and raises a timed alarm lockout after too many failures. It sits between the digit-entry/display path and the lock actuator and alarm outputs.

---
 rtl/seg_code_checker_pkg.sv | 27 ++
 rtl/seg_code_checker_seg7_to_digit.sv | 33 +++
 rtl/seg_code_checker.sv | 153 +++++++++++++++
 tb/tb_seg_code_checker.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_code_checker_pkg.sv
// rtl/seg_code_checker_pkg.sv - shared constants and types for the keypad code checker
// Purpose: segment-pattern constants, FSM state type and the invalid-digit code.
// Ports: none (package).
package seg_code_checker_pkg;

  // Active-low abcdefg patterns (bit6=a ... bit0=g, 0 = segment lit)
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GOT1   = 2'd1,
    OPEN   = 2'd2,
    LOCKED = 2'd3
  } state_e;

endpackage

// File: rtl/seg_code_checker_seg7_to_digit.sv
// rtl/seg_code_checker_seg7_to_digit.sv - combinational 7-segment to BCD decoder
// Purpose: maps an active-low segment pattern back to its digit; shared with display readback.
// Ports:
//   seg_i   in  7  active-low abcdefg pattern
//   digit_o out 4  decoded digit, DIGIT_INVALID when not a legal digit
//   err_o   out 1  pattern is not one of the ten digit patterns
module seg7_to_digit
  import seg_code_checker_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] digit_o,
  output logic       err_o
);

  always_comb begin
    digit_o = DIGIT_INVALID;
    err_o   = 1'b0;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: err_o   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_code_checker.sv
// rtl/seg_code_checker.sv - two-digit keypad code checker with failed-attempt lockout
// Purpose: decodes strobed segment digits, compares the pair against the stored code,
//          unlocks on a match and raises a timed alarm after MAX_TRIES failures.
// Ports:
//   CLK        in  1  system clock, rising edge
//   RST_N      in  1  asynchronous active-low reset
//   seg_in     in  7  active-low segment pattern
//   seg_valid  in  1  seg_in carries a new digit
//   clear      in  1  abort entry / relock
//   digit_out  out 4  last decoded digit
//   digit_err  out 1  last pattern was illegal
//   unlock     out 1  lock open
//   alarm      out 1  lockout active
//   tries_left out 2  attempts remaining before lockout
module seg_code_checker
  import seg_code_checker_pkg::*;
#(
  parameter int CODE_HI     = 9,
  parameter int CODE_LO     = 8,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] seg_in,
  input  logic       seg_valid,
  input  logic       clear,
  output logic [3:0] digit_out,
  output logic       digit_err,
  output logic       unlock,
  output logic       alarm,
  output logic [1:0] tries_left
);

  localparam int         CW        = $clog2(LOCK_CYCLES);
  localparam logic [3:0] CODE_HI_L = 4'(CODE_HI);
  localparam logic [3:0] CODE_LO_L = 4'(CODE_LO);
  localparam logic [1:0] MAX_L     = 2'(MAX_TRIES);
  localparam logic [CW-1:0] LOCK_LOAD = CW'(LOCK_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    first_q, first_d;
  logic [1:0]    fail_q, fail_d;
  logic [CW-1:0] lock_q, lock_d;
  logic [3:0]    dout_q, dout_d;
  logic          derr_q, derr_d;

  logic [3:0] dec_digit;
  logic       dec_err;
  logic       fail_evt;
  logic [1:0] fail_inc;

  seg7_to_digit u_dec (
    .seg_i   (seg_in),
    .digit_o (dec_digit),
    .err_o   (dec_err)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      first_q <= 4'd0;
      fail_q  <= 2'd0;
      lock_q  <= '0;
      dout_q  <= 4'd0;
      derr_q  <= 1'b0;
    end else begin
      first_q <= first_d;
      fail_q  <= fail_d;
      lock_q  <= lock_d;
      dout_q  <= dout_d;
      derr_q  <= derr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    fail_d   = fail_q;
    lock_d   = lock_q;
    dout_d   = dout_q;
    derr_d   = derr_q;
    fail_evt = 1'b0;
    fail_inc = fail_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (!clear && seg_valid) begin
          if (dec_err) begin
            fail_evt = 1'b1;
          end else begin
            first_d = dec_digit;
            state_d = GOT1;
          end
        end
      end
      GOT1: begin
        if (clear) begin
          state_d = IDLE;
        end else if (seg_valid) begin
          if (!dec_err && first_q == CODE_HI_L && dec_digit == CODE_LO_L) begin
            state_d = OPEN;
            fail_d  = 2'd0;
          end else begin
            fail_evt = 1'b1;
          end
        end
      end
      OPEN: begin
        if (clear) state_d = IDLE;
      end
      LOCKED: begin
        // Counter is loaded with LOCK_CYCLES-1, so the 0 cycle is the last alarm cycle.
        if (lock_q == '0) begin
          state_d = IDLE;
          fail_d  = 2'd0;
        end else begin
          lock_d = lock_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (fail_evt) begin
      fail_d = fail_inc;
      if (fail_inc == MAX_L) begin
        state_d = LOCKED;
        lock_d  = LOCK_LOAD;
      end else begin
        state_d = IDLE;
      end
    end

    // Display readback follows every digit that entry actually consumed.
    if (seg_valid && !clear && (state_q == IDLE || state_q == GOT1)) begin
      dout_d = dec_digit;
      derr_d = dec_err;
    end
  end

  always_comb begin
    unlock     = (state_q == OPEN);
    alarm      = (state_q == LOCKED);
    tries_left = (state_q == LOCKED) ? 2'd0 : (MAX_L - fail_q);
    digit_out  = dout_q;
    digit_err  = derr_q;
  end

endmodule

// File: tb/tb_seg_code_checker.sv
// tb/tb_seg_code_checker.sv - self-checking bench for the keypad code checker
module tb_seg_code_checker;

  localparam int CODE_HI     = 9;
  localparam int CODE_LO     = 8;
  localparam int MAX_TRIES   = 3;
  localparam int LOCK_CYCLES = 16;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [6:0] seg_in;
  logic       seg_valid;
  logic       clear;
  logic [3:0] digit_out;
  logic       digit_err;
  logic       unlock;
  logic       alarm;
  logic [1:0] tries_left;

  int errors = 0;
  int checks = 0;

  logic [6:0] pats [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  // Reference model: pending first digit (-1 = none), open flag, remaining alarm cycles,
  // failure count, and the last displayed digit.
  int m_first, m_lock_left, m_fails, m_dout;
  bit m_open, m_derr;

  seg_code_checker #(
    .CODE_HI(CODE_HI), .CODE_LO(CODE_LO), .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .seg_in(seg_in), .seg_valid(seg_valid), .clear(clear),
    .digit_out(digit_out), .digit_err(digit_err), .unlock(unlock), .alarm(alarm),
    .tries_left(tries_left)
  );

  always #5 CLK = ~CLK;

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (pats[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_first = -1; m_lock_left = 0; m_fails = 0; m_dout = 0; m_open = 0; m_derr = 0;
  endtask

  task automatic model_fail();
    m_first = -1;
    m_fails++;
    if (m_fails == MAX_TRIES) m_lock_left = LOCK_CYCLES;
  endtask

  task automatic model_step(input logic [6:0] s, input bit v, input bit c);
    int d;
    d = decode(s);
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_open) begin
      if (c) m_open = 0;
    end else if (c) begin
      m_first = -1;
    end else if (v) begin
      m_dout = (d < 0) ? 15 : d;
      m_derr = (d < 0);
      if (d < 0) model_fail();
      else if (m_first < 0) m_first = d;
      else if (m_first == CODE_HI && d == CODE_LO) begin
        m_open = 1; m_fails = 0; m_first = -1;
      end else model_fail();
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_tries;
    exp_tries = (m_lock_left > 0) ? 0 : MAX_TRIES - m_fails;
    check({tag, ".digit_out"},  {28'd0, digit_out},  32'(m_dout));
    check({tag, ".digit_err"},  {31'd0, digit_err},  32'(m_derr));
    check({tag, ".unlock"},     {31'd0, unlock},     32'(m_open));
    check({tag, ".alarm"},      {31'd0, alarm},      32'(m_lock_left > 0));
    check({tag, ".tries_left"}, {30'd0, tries_left}, 32'(exp_tries));
  endtask

  task automatic step(input string tag, input logic [6:0] s, input bit v, input bit c);
    seg_in = s; seg_valid = v; clear = c;
    @(posedge CLK);
    model_step(s, v, c);
    #1;
    check_all(tag);
  endtask

  task automatic digit(input string tag, input int d);
    step(tag, pats[d], 1'b1, 1'b0);
  endtask

  task automatic idle(input string tag);
    step(tag, 7'h7F, 1'b0, 1'b0);
  endtask

  initial begin
    int alarm_cycles;
    int r, k, guard;
    logic [6:0] s;
    bit v, c;

    RST_N = 1'b0; seg_in = 7'h7F; seg_valid = 1'b0; clear = 1'b0;
    model_reset();
    #2;
    check_all("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Correct code then relock
    digit("ok.d9", 9);
    check("ok.digit9", {28'd0, digit_out}, 32'd9);
    digit("ok.d8", 8);
    check("ok.unlock", {31'd0, unlock}, 32'd1);
    step("ok.clear", 7'h7F, 1'b0, 1'b1);
    check("ok.relock", {31'd0, unlock}, 32'd0);

    // Single failure, then recovery
    digit("f1.d9", 9);
    digit("f1.d7", 7);
    check("f1.tries", {30'd0, tries_left}, 32'd2);
    digit("f1.r9", 9);
    digit("f1.r8", 8);
    check("f1.unlock", {31'd0, unlock}, 32'd1);
    check("f1.tries3", {30'd0, tries_left}, 32'd3);
    step("f1.clear", 7'h7F, 1'b0, 1'b1);

    // Lockout after three wrong pairs; strobes during alarm ignored
    digit("lk.1", 1); digit("lk.2", 2);
    digit("lk.3", 3); digit("lk.4", 4);
    digit("lk.5", 5); digit("lk.6", 6);
    alarm_cycles = alarm ? 1 : 0;
    for (int i = 0; i < LOCK_CYCLES - 1; i++) begin
      digit("lk.ign", (i % 2 == 0) ? 9 : 8);
      if (alarm) alarm_cycles++;
    end
    idle("lk.end");
    check("lk.alarm_len", 32'(alarm_cycles), 32'(LOCK_CYCLES));
    check("lk.alarm_off", {31'd0, alarm}, 32'd0);
    digit("lk.r9", 9);
    digit("lk.r8", 8);
    check("lk.unlock", {31'd0, unlock}, 32'd1);
    step("lk.clear", 7'h7F, 1'b0, 1'b1);

    // Illegal pattern
    step("ill", 7'h7F, 1'b1, 1'b0);
    check("ill.err", {31'd0, digit_err}, 32'd1);
    check("ill.digit", {28'd0, digit_out}, 32'hF);
    check("ill.tries", {30'd0, tries_left}, 32'd2);

    // clear together with a digit in GOT1
    digit("sim.d9", 9);
    step("sim.clr8", pats[8], 1'b1, 1'b1);
    check("sim.dropped", {28'd0, digit_out}, 32'd9);
    digit("sim.d8", 8);
    check("sim.nounlock", {31'd0, unlock}, 32'd0);
    step("sim.clear", 7'h7F, 1'b0, 1'b1);

    // Async reset while locked with the down-counter at 5
    guard = 0;
    while (m_lock_left == 0 && guard < 4) begin
      step("ar.bad", 7'h7F, 1'b1, 1'b0);
      guard++;
    end
    check("ar.locked", {31'd0, alarm}, 32'd1);
    guard = 0;
    while (m_lock_left > 6 && guard < LOCK_CYCLES) begin
      idle("ar.wait");
      guard++;
    end
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    check("ar.alarm", {31'd0, alarm}, 32'd0);
    check("ar.tries", {30'd0, tries_left}, 32'd3);
    check_all("ar.reset");
    @(negedge CLK);
    RST_N = 1'b1;
    digit("ar.d9", 9);
    digit("ar.d8", 8);
    check("ar.unlock", {31'd0, unlock}, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      k = $urandom_range(0, 9);
      if (r < 30)      s = pats[CODE_HI];
      else if (r < 60) s = pats[CODE_LO];
      else if (r < 88) s = pats[k];
      else             s = 7'($urandom);
      v = ($urandom_range(0, 9) < 7);
      c = ($urandom_range(0, 19) == 0);
      step("rnd", s, v, c);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
